// File: rtl/udp_pkt_pkg.sv
// Shared types and constants for the UDP test-packet source: FSM states,
// header sizes, payload pattern encodings and LFSR feedback masks.
package udp_pkt_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_SEND,
    S_WAIT_DONE
  } state_t;

  localparam int IP_UDP_HDR = 28;
  localparam int UDP_HDR    = 8;

  localparam logic [1:0] MODE_FIXED = 2'd0;
  localparam logic [1:0] MODE_INC   = 2'd1;
  localparam logic [1:0] MODE_SEQ   = 2'd2;
  localparam logic [1:0] MODE_LFSR  = 2'd3;

  // Right-shifting Galois masks: term x^k of the polynomial sets bit k-1.
  function automatic logic [63:0] lfsr_taps(input int w);
    case (w)
      8:       return 64'h0000_0000_0000_00B8;
      16:      return 64'h0000_0000_0000_D008;
      32:      return 64'h0000_0000_8020_0003;
      default: return 64'hD800_0000_0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/udp_pattern_gen.sv
// Payload word generator: holds the word index and the LFSR, presents the
// current word and steps to the next one on each advance.
module udp_pattern_gen
  import udp_pkt_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] base,
  input  logic              load,
  input  logic              advance,
  input  logic [DATA_W-1:0] seq,
  output logic [DATA_W-1:0] word
);

  localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

  logic [1:0]        mode_q;
  logic [DATA_W-1:0] base_q;
  logic [DATA_W-1:0] idx;
  logic [DATA_W-1:0] lfsr;
  logic [DATA_W-1:0] idx_nx;
  logic [DATA_W-1:0] lfsr_nx;
  logic [DATA_W-1:0] seed;

  always_comb begin
    idx_nx  = idx + DATA_W'(1);
    lfsr_nx = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    seed    = (base == '0) ? DATA_W'(1) : base;
  end

  // Mode and base are captured on load so mid-packet config writes are inert.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_FIXED;
      base_q <= '0;
      idx    <= '0;
      lfsr   <= '0;
      word   <= '0;
    end else if (load) begin
      mode_q <= mode;
      base_q <= base;
      idx    <= '0;
      lfsr   <= seed;
      case (mode)
        MODE_FIXED, MODE_INC: word <= base;
        MODE_SEQ:             word <= seq;
        default:              word <= seed;
      endcase
    end else if (advance) begin
      idx  <= idx_nx;
      lfsr <= lfsr_nx;
      case (mode_q)
        MODE_FIXED: word <= base_q;
        MODE_INC:   word <= base_q + idx_nx;
        MODE_SEQ:   word <= idx_nx;
        default:    word <= lfsr_nx;
      endcase
    end
  end

endmodule

// File: rtl/udp_pkt_source.sv
// Programmable UDP test-packet source feeding the udp_top transmit request
// interface: periodic/software triggers, packet sequencing and statistics.
module udp_pkt_source
  import udp_pkt_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 32,
  parameter int LEN_W     = 16,
  parameter int MAX_WORDS = 368
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [LEN_W-1:0]  cfg_words,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_fixed,
  input  logic              sw_trig,
  output logic              tx_start,
  input  logic              tx_data_req,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_done,
  output logic [LEN_W-1:0]  tx_total_length,
  output logic [LEN_W-1:0]  tx_data_length,
  output logic              busy,
  output logic [31:0]       pkt_count,
  output logic [15:0]       drop_count
);

  localparam int BPW = DATA_W / 8;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [LEN_W-1:0] words_left;
  logic [LEN_W-1:0] w_clamp;
  logic             tick, trig, accept, drop, req_ok, last, adv;

  function automatic logic [LEN_W-1:0] clamp_words(input logic [LEN_W-1:0] w);
    if (w == '0) return LEN_W'(1);
    if (32'(w) > MAX_WORDS) return LEN_W'(MAX_WORDS);
    return w;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [LEN_W-1:0] byte_len(input logic [LEN_W-1:0] w, input int hdr);
    return LEN_W'(32'(w) * BPW + hdr);
  endfunction

  assign w_clamp = clamp_words(cfg_words);
  assign tick    = enable && (cfg_period != '0) && (cnt == cfg_period - CNT_W'(1));
  assign trig    = sw_trig | tick;
  assign drop    = trig && (state != S_IDLE);
  assign adv     = req_ok && !last;
  assign busy    = (state != S_IDLE);

  // Free-running period counter; a period lowered below cnt wraps without a tick.
  always_ff @(posedge clk) begin
    if (rst || !enable || cfg_period == '0 || tick || cnt >= cfg_period) cnt <= '0;
    else                                                                 cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    req_ok   = 1'b0;
    last     = 1'b0;
    case (state)
      S_IDLE: if (trig) begin
        accept   = 1'b1;
        state_nx = S_START;
      end
      S_START: state_nx = S_SEND;
      S_SEND: if (tx_data_req) begin
        req_ok = 1'b1;
        if (words_left == LEN_W'(1)) begin
          last     = 1'b1;
          state_nx = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: if (tx_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_start        <= 1'b0;
      pkt_count       <= '0;
      drop_count      <= '0;
      words_left      <= '0;
      tx_total_length <= '0;
      tx_data_length  <= '0;
    end else begin
      tx_start <= (state == S_START);
      if (state == S_START) pkt_count <= pkt_count + 32'd1;
      if (drop) drop_count <= sat_inc16(drop_count);
      if (accept) begin
        words_left      <= w_clamp;
        tx_total_length <= byte_len(w_clamp, IP_UDP_HDR);
        tx_data_length  <= byte_len(w_clamp, UDP_HDR);
      end else if (req_ok) begin
        words_left <= words_left - LEN_W'(1);
      end
    end
  end

  // The last word is not advanced past, so tx_data holds it until the next load.
  udp_pattern_gen #(
    .DATA_W (DATA_W)
  ) u_pattern_gen (
    .clk     (clk),
    .rst     (rst),
    .mode    (cfg_mode),
    .base    (cfg_fixed),
    .load    (accept),
    .advance (adv),
    .seq     (DATA_W'(pkt_count)),
    .word    (tx_data)
  );

endmodule

// File: tb/tb_udp_pkt_source.sv
// Directed bench for udp_pkt_source: periodic run, pattern modes, drops,
// length boundaries, trigger collision and mid-packet reset.
`timescale 1ns/1ps
module tb_udp_pkt_source;

  localparam int DATA_W    = 32;
  localparam int CNT_W     = 32;
  localparam int LEN_W     = 16;
  localparam int MAX_WORDS = 368;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic [CNT_W-1:0]  cfg_period = '0;
  logic [LEN_W-1:0]  cfg_words = '0;
  logic [1:0]        cfg_mode = '0;
  logic [DATA_W-1:0] cfg_fixed = '0;
  logic              sw_trig = 1'b0;
  logic              tx_data_req = 1'b0;
  logic              tx_done = 1'b0;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic [LEN_W-1:0]  tx_total_length;
  logic [LEN_W-1:0]  tx_data_length;
  logic              busy;
  logic [31:0]       pkt_count;
  logic [15:0]       drop_count;

  int          nvec = 0;
  int          nmis = 0;
  int          cyc  = 0;
  int          t_last;
  logic [31:0] got [0:511];
  logic [31:0] s;
  logic        seen;
  logic [31:0] exp_seq [0:3] = '{32'd2, 32'd1, 32'd2, 32'd3};
  logic [31:0] exp_lz  [0:2] = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002};

  udp_pkt_source #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .LEN_W(LEN_W), .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_period(cfg_period),
    .cfg_words(cfg_words), .cfg_mode(cfg_mode), .cfg_fixed(cfg_fixed),
    .sw_trig(sw_trig), .tx_start(tx_start), .tx_data_req(tx_data_req),
    .tx_data(tx_data), .tx_done(tx_done), .tx_total_length(tx_total_length),
    .tx_data_length(tx_data_length), .busy(busy), .pkt_count(pkt_count),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] lfsr_ref(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_start(input int budget);
    for (int k = 0; k < budget && tx_start !== 1'b1; k++) step(1);
    check_eq("start_seen", tx_start, 1);
  endtask

  task automatic trig_pkt(input int words, input int mode, input logic [31:0] fixed);
    cfg_words = LEN_W'(words);
    cfg_mode  = 2'(mode);
    cfg_fixed = fixed;
    sw_trig   = 1'b1;
    step(1);
    sw_trig   = 1'b0;
    wait_start(4);
  endtask

  task automatic consume(input int n);
    tx_data_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      got[i] = tx_data;
      step(1);
    end
    tx_data_req = 1'b0;
  endtask

  task automatic check_lens(input int tot, input int dl);
    check_eq("total_len", tx_total_length, tot);
    check_eq("data_len", tx_data_length, dl);
  endtask

  task automatic finish_pkt();
    tx_done = 1'b1;
    step(1);
    tx_done = 1'b0;
    check_eq("idle_after_done", busy, 0);
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_tx_start"}, tx_start, 0);
    check_eq({pfx, "_tx_data"}, tx_data, 0);
    check_eq({pfx, "_total_len"}, tx_total_length, 0);
    check_eq({pfx, "_data_len"}, tx_data_length, 0);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_pkt_count"}, pkt_count, 0);
    check_eq({pfx, "_drop_count"}, drop_count, 0);
  endtask

  initial begin
    rst = 1'b1;
    step(2);
    check_all_zero("reset");
    rst = 1'b0;

    // Periodic run, 100-cycle period, one word per packet
    cfg_period = 100;
    cfg_words  = 1;
    cfg_mode   = 0;
    cfg_fixed  = 32'h2829_2A2B;
    enable     = 1'b1;
    for (int p = 0; p < 3; p++) begin
      wait_start(150);
      if (p > 0) check_eq("period", cyc - t_last, 100);
      t_last = cyc;
      check_eq("period_data", tx_data, 32'h2829_2A2B);
      check_lens(32, 12);
      step(5);
      consume(1);
      step(20);
      finish_pkt();
    end
    enable = 1'b0;
    cfg_period = 0;
    check_eq("period_pkts", pkt_count, 3);

    // Pattern modes, W=4, base 0x10
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    trig_pkt(4, 1, 32'h10);
    check_lens(44, 24);
    consume(4);
    for (int i = 0; i < 4; i++) check_eq("mode1_word", got[i], 32'h10 + i);
    finish_pkt();

    trig_pkt(4, 3, 32'h10);
    check_lens(44, 24);
    consume(4);
    s = 32'h10;
    for (int i = 0; i < 4; i++) begin
      check_eq("mode3_word", got[i], s);
      s = lfsr_ref(s);
    end
    finish_pkt();

    trig_pkt(4, 2, 32'h10);
    check_lens(44, 24);
    consume(4);
    for (int i = 0; i < 4; i++) check_eq("mode2_word", got[i], exp_seq[i]);
    repeat (3) begin
      sw_trig = 1'b1;
      step(1);
      sw_trig = 1'b0;
      step(1);
    end
    check_eq("drops3", drop_count, 3);
    check_eq("drops_pkt", pkt_count, 3);
    check_eq("wait_busy", busy, 1);
    check_lens(44, 24);
    check_eq("last_word_held", tx_data, 3);
    finish_pkt();

    // Word-count boundaries and LFSR zero seed
    trig_pkt(0, 0, 32'hA5A5_0001);
    check_lens(32, 12);
    check_eq("w0_data", tx_data, 32'hA5A5_0001);
    consume(1);
    check_eq("w0_one_word", busy, 1);
    finish_pkt();

    trig_pkt(1000, 1, 32'h0);
    check_lens(1500, 1480);
    consume(367);
    check_eq("clamp_w366", got[366], 366);
    check_eq("clamp_w367", tx_data, 367);
    consume(1);
    check_eq("clamp_busy", busy, 1);
    consume(2);
    check_eq("extra_req_data", tx_data, 367);
    finish_pkt();

    trig_pkt(3, 3, 32'h0);
    consume(3);
    for (int i = 0; i < 3; i++) check_eq("seed0_word", got[i], exp_lz[i]);
    finish_pkt();

    // sw_trig coincident with the period tick; tx_done during SEND
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    cfg_words  = 4;
    cfg_mode   = 0;
    cfg_fixed  = 32'h55;
    cfg_period = 4;
    enable     = 1'b1;
    step(3);
    sw_trig = 1'b1;
    step(1);
    sw_trig    = 1'b0;
    enable     = 1'b0;
    cfg_period = 0;
    check_eq("lat_n1", tx_start, 0);
    step(1);
    check_eq("lat_n2", tx_start, 1);
    check_eq("coll_pkt", pkt_count, 1);
    check_eq("coll_drop", drop_count, 0);
    step(1);
    check_eq("start_one_cycle", tx_start, 0);
    consume(2);
    tx_done = 1'b1;
    step(1);
    tx_done = 1'b0;
    check_eq("done_in_send", busy, 1);
    consume(2);
    check_eq("coll_data", tx_data, 32'h55);
    check_eq("coll_wait", busy, 1);
    finish_pkt();
    check_eq("coll_pkt_final", pkt_count, 1);

    // Reset after 2 of 4 words
    trig_pkt(4, 1, 32'h10);
    consume(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_all_zero("midrst");
    seen = 1'b0;
    repeat (5) begin
      step(1);
      seen = seen | tx_start;
    end
    check_eq("no_start_after_rst", seen, 0);
    trig_pkt(4, 1, 32'h20);
    check_eq("fresh_pkt", pkt_count, 1);
    check_eq("fresh_data", tx_data, 32'h20);
    consume(4);
    finish_pkt();

    // drop_count saturation
    trig_pkt(1, 0, 32'h77);
    consume(1);
    sw_trig = 1'b1;
    step(65540);
    sw_trig = 1'b0;
    check_eq("drop_sat", drop_count, 16'hFFFF);
    check_eq("sat_pkt", pkt_count, 2);
    finish_pkt();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/udp_pkt_source.md
# udp_pkt_source

Parametrised UDP test-packet source that drives the transmit-side request interface of `udp_top`. It replaces a hard-wired trigger counter and constant payload with a programmable period, payload length and pattern generator. It also adds a single-shot trigger, back-pressure against an in-flight packet, and packet/drop statistics. It sits between the board-level wrapper and `udp_top` in the `e_rxc` domain, and is fully synchronous to one clock.

## Interface
Parameters:
- `DATA_W`, 32: payload word width in bits; one of 8, 16, 32, 64.
- `CNT_W`, 32: period counter width.
- `LEN_W`, 16: width of the length outputs.
- `MAX_WORDS`, 368: clamp for `cfg_words`, equal to 1472 payload bytes at 32 bits.

Ports:
- `clk` in 1: single clock (connected to the 125 MHz `e_rxc`).
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: periodic triggering on; when low, the period counter is held at 0.
- `cfg_period` in CNT_W: trigger period in clk cycles; 0 means periodic off, sw_trig only.
- `cfg_words` in LEN_W: payload words per packet; 0 is treated as 1; values above MAX_WORDS are clamped to MAX_WORDS.
- `cfg_mode` in 2: payload pattern; 0 fixed, 1 incrementing, 2 sequence-tagged, 3 LFSR.
- `cfg_fixed` in DATA_W: constant, base or seed value.
- `sw_trig` in 1: single-cycle request for one packet.
- `tx_start` out 1: one-cycle start pulse to `udp_top`.
- `tx_data_req` in 1: word-consume strobe from `udp_top`.
- `tx_data` out DATA_W: current payload word.
- `tx_done` in 1: end-of-frame pulse from `udp_top`.
- `tx_total_length` out LEN_W: IP total length, bytes = words·DATA_W/8 + 28.
- `tx_data_length` out LEN_W: UDP length, bytes = words·DATA_W/8 + 8.
- `busy` out 1: high in any state other than IDLE.
- `pkt_count` out 32: packets started; wraps.
- `drop_count` out 16: triggers rejected while busy; saturates at 0xFFFF.

## Operation
- FSM states: IDLE → START → SEND → WAIT_DONE → IDLE.
- Trigger:
  - A trigger is `sw_trig`, or the period tick. The tick fires when `enable`, `cfg_period≠0` and `cnt==cfg_period-1`; `cnt` then returns to 0.
  - A simultaneous `sw_trig` and tick count as one trigger.
- IDLE + trigger:
  - Latch the clamped word count W, `cfg_mode` and `cfg_fixed`.
  - Compute both lengths from W.
  - Load word 0.
  - Go to START.
- START:
  - Assert `tx_start` for exactly one cycle.
  - Increment `pkt_count`.
  - Go to SEND.
- SEND:
  - Each `tx_data_req` advances the word index i.
  - After the W-th req, go to WAIT_DONE.
  - `tx_data` keeps its last word after that point.
- WAIT_DONE: on `tx_done`, go to IDLE.
- `tx_done` is ignored in all other states.
- A trigger in any non-IDLE state increments `drop_count` (saturating) and starts nothing.
- Patterns, for word index i:
  - Mode 0: `cfg_fixed`.
  - Mode 1: `cfg_fixed + i`, modulo 2^DATA_W.
  - Mode 2: word 0 is the zero-extended `pkt_count` value of this packet; word i>0 is i.
  - Mode 3: Galois LFSR seeded with `cfg_fixed`; a seed of 0 is replaced by 1; the LFSR advances once per req.
- Mid-packet changes to `cfg_*` have no effect until the next trigger.
- `req` pulses arriving in IDLE, START or WAIT_DONE are ignored.

## Timing
- Reset value of every output: 0. FSM to IDLE, `cnt`=0, LFSR cleared.
- Trigger at edge N → `tx_start` high in cycle N+2.
- Word 0 is valid on `tx_data` from the `tx_start` cycle onward.
- `tx_data` holds its value between reqs.
- A req sampled at edge k → word i+1 is valid from cycle k+1.
- Back-to-back reqs, one per cycle, are supported.
- Lengths are stable from the `tx_start` cycle until return to IDLE.
- `cnt` keeps running while busy, so the period is independent of packet duration.
- Boundary cases:
  - A `cfg_period` write below the current `cnt` wraps `cnt` to 0 on the next cycle, with no tick.
  - `cfg_period=1` fires every cycle while enabled.
- Reset asserted mid-packet: the next cycle is IDLE with all outputs 0; no `tx_start` is emitted.

## Structure
- Package `udp_pkt_pkg`:
  - FSM state enum.
  - Header byte constants, `IP_UDP_HDR=28` and `UDP_HDR=8`.
  - Mode encodings.
  - LFSR tap table per DATA_W: 8: x⁸+x⁶+x⁵+x⁴+1; 16: x¹⁶+x¹⁵+x¹³+x⁴+1; 32: x³²+x²²+x²+x+1; 64: x⁶⁴+x⁶³+x⁶¹+x⁶⁰+1.
- Sub-module `udp_pattern_gen`:
  - Inputs: mode, base, load, advance, seq.
  - Output: word.
  - Contains the index counter and the LFSR.
- FSM, period counter and statistics live in the top.

## Test plan
- Period run: `cfg_period`=100, `enable`, W=1, mode 0, `cfg_fixed`=0x28292A2B, req issued 5 cycles after each `tx_start`, `tx_done` returned 20 cycles later → `tx_start` every 100 cycles; `tx_data`=0x28292A2B; lengths 32/12.
- Pattern modes, W=4 with `cfg_fixed`=0x10:
  - Mode 1 → 0x10, 0x11, 0x12, 0x13.
  - Mode 2, third packet → 2, 1, 2, 3.
  - Mode 3 → LFSR sequence matches the reference model.
  - Lengths 44/24 in every mode.
- Drops: `sw_trig` ×3 during WAIT_DONE → `drop_count`=3; `pkt_count` unchanged; `drop_count` saturates at 0xFFFF.
- Boundaries:
  - `cfg_words`=0 → W=1, lengths 32/12.
  - `cfg_words`=1000 → W=368, lengths 1500/1480.
  - Extra reqs after the last word leave `tx_data` unchanged.
- Collisions: `sw_trig` coincident with the period tick → one packet, `drop_count` 0. `tx_done` while in SEND → ignored.
- Reset in SEND after 2 of 4 words → all outputs 0 next cycle. Next trigger → fresh packet with `pkt_count`=1.
